dmem_port_arb: RTL and testbench

//   Shares one dmem port between the pipeline load/store path (requester A, from stg4ma/stg4mo) and a

---
 rtl/dmem_port_arb_pkg.sv | 21 ++
 rtl/dmem_port_arb.sv | 145 ++++++++++++++
 tb/tb_dmem_port_arb.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/dmem_port_arb_pkg.sv
// Shared widths, FSM state encodings and read-owner codes for the dmem port arbiter.
// Imported by the arbiter and by anything that decodes its state.
package dmem_port_arb_pkg;

   localparam int SIZE_ADDR = 8;
   localparam int SIZE_DATA = 16;
   localparam int HBIT_ADDR = SIZE_ADDR - 1;
   localparam int HBIT_DATA = SIZE_DATA - 1;

   typedef enum logic {
      ST_AOWN  = 1'b0,
      ST_BLOCK = 1'b1
   } arb_state_t;

   typedef enum logic [1:0] {
      RD_NONE = 2'd0,
      RD_A    = 2'd1,
      RD_B    = 2'd2
   } rd_owner_t;

endpackage

// File: rtl/dmem_port_arb.sv
// Two-master arbiter for the single dmem port: pipeline (A) has priority, the debug/DMA
// master (B) is protected by a starvation counter and a bounded lock (burst) mode.
module dmem_port_arb
   import dmem_port_arb_pkg::*;
#(
   parameter int STARVE_MAX = 4,
   parameter int LOCK_MAX   = 16
) (
   input  logic             iw_clk,
   input  logic             iw_rst,
   input  logic             iw_a_req,
   input  logic             iw_a_we,
   input  logic [HBIT_ADDR:0] iw_a_addr,
   input  logic [HBIT_DATA:0] iw_a_wdata,
   output logic             ow_a_gnt,
   output logic             ow_a_stall,
   output logic             ow_a_rvalid,
   output logic [HBIT_DATA:0] ow_a_rdata,
   input  logic             iw_b_req,
   input  logic             iw_b_we,
   input  logic             iw_b_lock,
   input  logic [HBIT_ADDR:0] iw_b_addr,
   input  logic [HBIT_DATA:0] iw_b_wdata,
   output logic             ow_b_gnt,
   output logic             ow_b_rvalid,
   output logic [HBIT_DATA:0] ow_b_rdata,
   output logic             ow_mem_we,
   output logic [HBIT_ADDR:0] ow_mem_addr,
   output logic [HBIT_DATA:0] ow_mem_wdata,
   input  logic [HBIT_DATA:0] iw_mem_rdata
);

   localparam logic [3:0] STARVE_LIM = STARVE_MAX[3:0];
   localparam logic [7:0] LOCK_LIM   = LOCK_MAX[7:0];

   arb_state_t state_reg, state_next;
   rd_owner_t  rd_owner_reg, rd_owner_next;
   logic [3:0] starve_reg, starve_next;
   logic [7:0] lock_cnt_reg, lock_cnt_next;
   logic       lock_block_reg, lock_block_next;
   logic       a_gnt, b_gnt;

   always_ff @(posedge iw_clk or posedge iw_rst) begin
      if (iw_rst) begin
         state_reg      <= ST_AOWN;
         rd_owner_reg   <= RD_NONE;
         starve_reg     <= 4'd0;
         lock_cnt_reg   <= 8'd0;
         lock_block_reg <= 1'b0;
      end else begin
         state_reg      <= state_next;
         rd_owner_reg   <= rd_owner_next;
         starve_reg     <= starve_next;
         lock_cnt_reg   <= lock_cnt_next;
         lock_block_reg <= lock_block_next;
      end
   end

   always_comb begin
      a_gnt           = 1'b0;
      b_gnt           = 1'b0;
      state_next      = state_reg;
      lock_cnt_next   = lock_cnt_reg;
      lock_block_next = lock_block_reg;
      case (state_reg)
         ST_AOWN: begin
            if (iw_a_req && !(iw_b_req && starve_reg == STARVE_LIM))
               a_gnt = 1'b1;
            else if (iw_b_req)
               b_gnt = 1'b1;
            // The grant that lifts a forced-release block does not itself open a new burst.
            if (b_gnt) begin
               lock_block_next = 1'b0;
               if (iw_b_lock && !lock_block_reg) begin
                  if (LOCK_LIM == 8'd1) begin
                     lock_block_next = 1'b1;
                  end else begin
                     state_next    = ST_BLOCK;
                     lock_cnt_next = 8'd1;
                  end
               end
            end
         end
         ST_BLOCK: begin
            if (iw_b_req) begin
               b_gnt = 1'b1;
               if (!iw_b_lock) begin
                  state_next    = ST_AOWN;
                  lock_cnt_next = 8'd0;
               end else if (lock_cnt_reg + 8'd1 == LOCK_LIM) begin
                  state_next      = ST_AOWN;
                  lock_cnt_next   = 8'd0;
                  lock_block_next = 1'b1;
               end else begin
                  lock_cnt_next = lock_cnt_reg + 8'd1;
               end
            end else begin
               a_gnt         = iw_a_req;
               state_next    = ST_AOWN;
               lock_cnt_next = 8'd0;
            end
         end
         default: state_next = ST_AOWN;
      endcase
      if (iw_rst) begin
         a_gnt = 1'b0;
         b_gnt = 1'b0;
      end
   end

   always_comb begin
      starve_next = 4'd0;
      if (iw_b_req && !b_gnt)
         starve_next = (starve_reg == 4'hF) ? starve_reg : starve_reg + 4'd1;
      rd_owner_next = RD_NONE;
      if (a_gnt && !iw_a_we)
         rd_owner_next = RD_A;
      else if (b_gnt && !iw_b_we)
         rd_owner_next = RD_B;
   end

   // Idle port still presents A's address so a following A read sees a stable bus.
   always_comb begin
      ow_mem_we    = 1'b0;
      ow_mem_addr  = iw_a_addr;
      ow_mem_wdata = '0;
      if (b_gnt) begin
         ow_mem_we    = iw_b_we;
         ow_mem_addr  = iw_b_addr;
         ow_mem_wdata = iw_b_wdata;
      end else if (a_gnt) begin
         ow_mem_we    = iw_a_we;
         ow_mem_wdata = iw_a_wdata;
      end
   end

   assign ow_a_gnt    = a_gnt;
   assign ow_b_gnt    = b_gnt;
   assign ow_a_stall  = iw_a_req & ~a_gnt;
   assign ow_a_rvalid = (rd_owner_reg == RD_A);
   assign ow_b_rvalid = (rd_owner_reg == RD_B);
   assign ow_a_rdata  = ow_a_rvalid ? iw_mem_rdata : '0;
   assign ow_b_rdata  = ow_b_rvalid ? iw_mem_rdata : '0;

endmodule

// File: tb/tb_dmem_port_arb.sv
// Directed bench for dmem_port_arb: grants checked each cycle, read data checked through a
// scoreboard of expected per-cycle read responses backed by a reference memory image.
module tb_dmem_port_arb;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        fill_en = 1'b1;
   logic        a_req = 1'b0, a_we = 1'b0;
   logic [7:0]  a_addr = 8'd0;
   logic [15:0] a_wdata = 16'd0;
   logic        b_req = 1'b0, b_we = 1'b0, b_lock = 1'b0;
   logic [7:0]  b_addr = 8'd0;
   logic [15:0] b_wdata = 16'd0;
   logic        a_gnt, a_stall, a_rvalid, b_gnt, b_rvalid, mem_we;
   logic [15:0] a_rdata, b_rdata, mem_wdata;
   logic [15:0] mem_rdata = 16'd0;
   logic [7:0]  mem_addr;

   logic [15:0] mem [256];
   logic [15:0] exp_mem [256];

   typedef struct {
      logic        av;
      logic        bv;
      logic [15:0] d;
   } exp_t;
   exp_t sb[$];

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   dmem_port_arb #(.STARVE_MAX(4), .LOCK_MAX(16)) dut (
      .iw_clk(clk), .iw_rst(rst),
      .iw_a_req(a_req), .iw_a_we(a_we), .iw_a_addr(a_addr), .iw_a_wdata(a_wdata),
      .ow_a_gnt(a_gnt), .ow_a_stall(a_stall), .ow_a_rvalid(a_rvalid), .ow_a_rdata(a_rdata),
      .iw_b_req(b_req), .iw_b_we(b_we), .iw_b_lock(b_lock), .iw_b_addr(b_addr),
      .iw_b_wdata(b_wdata), .ow_b_gnt(b_gnt), .ow_b_rvalid(b_rvalid), .ow_b_rdata(b_rdata),
      .ow_mem_we(mem_we), .ow_mem_addr(mem_addr), .ow_mem_wdata(mem_wdata),
      .iw_mem_rdata(mem_rdata)
   );

   function automatic logic [15:0] pat(int i);
      logic [15:0] v;
      v = 16'(i * 7 + 3);
      if (i == 16) v = 16'h0055;
      return v;
   endfunction

   // Behavioural dmem: one-cycle registered read.
   always @(posedge clk) begin
      if (fill_en) begin
         for (int i = 0; i < 256; i++) mem[i] <= pat(i);
      end else if (mem_we) begin
         mem[mem_addr] <= mem_wdata;
      end
      mem_rdata <= mem[mem_addr];
   end

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic reset_sb();
      exp_t e;
      e.av = 1'b0; e.bv = 1'b0; e.d = 16'd0;
      sb.delete();
      sb.push_back(e);
   endtask

   // One cycle: check grants/mux at the negedge, retire last cycle's read, queue this one.
   task automatic step(string tag, logic ea, logic eb);
      exp_t e, n;
      @(negedge clk);
      check({tag, ".a_gnt"}, 32'(a_gnt), 32'(ea));
      check({tag, ".b_gnt"}, 32'(b_gnt), 32'(eb));
      check({tag, ".a_stall"}, 32'(a_stall), 32'(a_req & ~ea));
      if (ea || eb) begin
         check({tag, ".mem_addr"}, 32'(mem_addr), eb ? 32'(b_addr) : 32'(a_addr));
         check({tag, ".mem_we"}, 32'(mem_we), eb ? 32'(b_we) : 32'(a_we));
      end
      if (sb.size() == 0) begin
         fails++;
         $error("FAIL %s.scoreboard: observed empty expected entry", tag);
      end else begin
         e = sb.pop_front();
         check({tag, ".a_rvalid"}, 32'(a_rvalid), 32'(e.av));
         check({tag, ".b_rvalid"}, 32'(b_rvalid), 32'(e.bv));
         check({tag, ".a_rdata"}, 32'(a_rdata), e.av ? 32'(e.d) : 32'd0);
         check({tag, ".b_rdata"}, 32'(b_rdata), e.bv ? 32'(e.d) : 32'd0);
      end
      n.av = ea & ~a_we;
      n.bv = eb & ~b_we;
      n.d  = n.av ? exp_mem[a_addr] : (n.bv ? exp_mem[b_addr] : 16'd0);
      if (ea && a_we) exp_mem[a_addr] = a_wdata;
      if (eb && b_we) exp_mem[b_addr] = b_wdata;
      sb.push_back(n);
      $display("[TB] %s a_gnt=%b b_gnt=%b a_rv=%b a_rd=%h b_rv=%b b_rd=%h",
               tag, a_gnt, b_gnt, a_rvalid, a_rdata, b_rvalid, b_rdata);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 256; i++) exp_mem[i] = pat(i);
      // Reset: grants forced low even with both requesting.
      a_req = 1'b1; b_req = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst.a_gnt", 32'(a_gnt), 32'd0);
      check("rst.b_gnt", 32'(b_gnt), 32'd0);
      check("rst.a_rvalid", 32'(a_rvalid), 32'd0);
      check("rst.mem_we", 32'(mem_we), 32'd0);
      @(posedge clk); #1;
      fill_en = 1'b0; rst = 1'b0;
      a_req = 1'b0; b_req = 1'b0;
      reset_sb();

      // 1: A alone reads 0x10.
      a_req = 1'b1; a_we = 1'b0; a_addr = 8'h10;
      step("t1.rd", 1'b1, 1'b0);
      a_req = 1'b0;
      step("t1.idle", 1'b0, 1'b0);

      // 2: continuous contention, B wins every fifth cycle.
      a_req = 1'b1; b_req = 1'b1; b_we = 1'b0; b_lock = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         a_addr = 8'(c); b_addr = 8'(8'h80 + c);
         step($sformatf("t2.c%0d", c), (c % 5) != 0, (c % 5) == 0);
      end
      a_req = 1'b0; b_req = 1'b0;
      step("t2.idle", 1'b0, 1'b0);

      // 3: 16-beat lock limit, forced release, re-entry blocked until one plain B grant.
      b_req = 1'b1; b_lock = 1'b1;
      for (int c = 1; c <= 16; c++) begin
         a_req = (c >= 2); a_addr = 8'h40; b_addr = 8'(8'hA0 + c);
         step($sformatf("t3.b%0d", c), 1'b0, 1'b1);
      end
      a_req = 1'b1; step("t3.c17", 1'b1, 1'b0);
      a_req = 1'b0; step("t3.c18", 1'b0, 1'b1);
      a_req = 1'b1; step("t3.c19", 1'b1, 1'b0);
      a_req = 1'b0; step("t3.c20", 1'b0, 1'b1);
      a_req = 1'b1; step("t3.c21", 1'b0, 1'b1);
      b_req = 1'b0; step("t3.c22", 1'b1, 1'b0);
      a_req = 1'b0; b_lock = 1'b0;
      step("t3.idle", 1'b0, 1'b0);

      // 5: B writes 0xAB at 0x20, A reads it back next cycle.
      b_req = 1'b1; b_we = 1'b1; b_addr = 8'h20; b_wdata = 16'h00AB;
      step("t5.bwr", 1'b0, 1'b1);
      b_req = 1'b0; b_we = 1'b0;
      a_req = 1'b1; a_addr = 8'h20;
      step("t5.ard", 1'b1, 1'b0);
      a_req = 1'b0;
      step("t5.idle", 1'b0, 1'b0);

      // 4: lock for three beats then lock dropped on the fourth beat.
      b_req = 1'b1; b_lock = 1'b1; b_addr = 8'h60; a_addr = 8'h61;
      step("t4.b1", 1'b0, 1'b1);
      a_req = 1'b1;
      step("t4.b2", 1'b0, 1'b1);
      step("t4.b3", 1'b0, 1'b1);
      b_lock = 1'b0;
      step("t4.b4", 1'b0, 1'b1);
      step("t4.a", 1'b1, 1'b0);
      a_req = 1'b0; b_req = 1'b0;
      step("t4.idle", 1'b0, 1'b0);

      // 6: reset pulse while a granted read is in flight.
      a_req = 1'b1; a_addr = 8'h30;
      step("t6.rd", 1'b1, 1'b0);
      rst = 1'b1;
      #1;
      check("t6.rst_a_gnt", 32'(a_gnt), 32'd0);
      check("t6.rst_a_rvalid", 32'(a_rvalid), 32'd0);
      a_req = 1'b0;
      #1;
      rst = 1'b0;
      reset_sb();
      step("t6.idle", 1'b0, 1'b0);
      a_req = 1'b1; b_req = 1'b1; b_lock = 1'b1; a_addr = 8'h31; b_addr = 8'h32;
      step("t6.aown", 1'b1, 1'b0);
      a_req = 1'b0; b_req = 1'b0; b_lock = 1'b0;
      step("t6.end", 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
